mult_seq_scheduler: RTL and testbench
=====================================

Name: mult_seq_scheduler

Overview:
- Time-multiplexed unsigned WxW multiplier built around a single 2x2 partial-product core.
- Sequences the core over all (A-slice, B-slice) pairs and accumulates shifted partial products.
- Replaces four parallel 2x2 instances where area matters more than latency.
- Valid/ready on both input and output, so it drops into streaming test harnesses and the multiplier-comparison bench.

Parameters:
- W, 4, operand width; must be even and in {4,6,8}. Slice count N=W/2; step count S=N*N.

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst_n  in  1  synchronous active-low reset
- in_valid  in  1  operand pair offered
- in_ready  out  1  scheduler can accept operands
- a  in  W  multiplicand, unsigned
- b  in  W  multiplier, unsigned
- out_valid  out  1  product available
- out_ready  in  1  consumer accepts product
- p  out  2W  product, unsigned
- busy  out  1  state is RUN
- step  out  $clog2(S)  current step index, for debug; 0 outside RUN

Behaviour:
- Reset: rst_n low at an edge gives state=IDLE, acc=0, idx=0, latched operands=0. Resulting outputs: in_ready=1, out_valid=0, p=0, busy=0, step=0. Reset wins over any handshake at the same edge.
- Reset mid-RUN or mid-DONE discards the operation; no out_valid follows.
- States: IDLE, RUN, DONE. Encoded as an enum.
- IDLE:
  - in_ready=1.
  - At an edge with in_valid=1, latch a and b, clear acc, set idx=0, go to RUN.
- RUN:
  - in_ready=0, busy=1.
  - For idx, i=idx/N (A slice) and j=idx%N (B slice).
  - The core multiplies a[2i+1:2i] by b[2j+1:2j] into a 4-bit pp.
  - At each edge, acc += pp << 2(i+j), idx++.
  - At the edge that processes idx=S-1, go to DONE.
  - Slice order is row-major: A slice outer, B slice inner.
- DONE:
  - out_valid=1, p=acc, held stable while out_ready=0.
  - At an edge with out_ready=1, go to IDLE.
  - in_ready stays 0 in DONE; there is no same-cycle re-accept.
- Latency: handshake at edge k, then out_valid high after edge k+S (4 cycles for W=4). Throughput is one result per S+2 cycles at best.
- Arithmetic:
  - acc is 2W bits; no overflow is possible because the maximum value is (2^W-1)^2.
  - pp is zero-extended before the shift.
- p drives acc in every state. p is only meaningful while out_valid=1.
- in_valid deasserting in RUN or DONE has no effect. Operand changes after the accept edge are ignored.

Optional Feature:
- Macro: MULT_SEQ_SKIP_ZERO_EN.
- Defined:
  - At the accept edge, compute an S-bit mask; bit idx is set iff both the A slice and the B slice for that idx are nonzero.
  - RUN visits only set bits in ascending order, one per cycle. step reports the visited idx.
  - If the mask is empty, RUN lasts exactly one cycle with no accumulate, and DONE follows with p=0.
  - Latency = max(popcount(mask), 1).
- Undefined: all S steps always execute and no mask logic is present.

Decomposition:
- Package mult_seq_pkg:
  - state enum {IDLE, RUN, DONE}
  - SLICE_W=2
  - functions n_slices(W) and n_steps(W)
  - localparam check helper that rejects odd W
- Sub-module mult2_core:
  - purely combinational 2x2 unsigned multiply with 4-bit output
  - port-compatible with the RL-generated 2x2 cores, so any of them can be substituted for area/correctness comparison
- Scheduler FSM, index counter, shifter and accumulator live in the top.

Test Plan:
- W=4, a=15, b=15, out_ready=1 → out_valid exactly 4 cycles after accept edge, p=225, then in_ready=1 next cycle.
- W=4, a=9, b=6, out_ready held 0 for 5 cycles after out_valid → p=54 stable throughout, single transfer, no second out_valid.
- W=4, exhaustive 256 pairs back-to-back with random out_ready → every p equals a*b, in order, no drops or duplicates.
- W=4, accept a=7, b=13, pull rst_n low at the 2nd RUN cycle for 1 cycle → no out_valid, in_ready=1 after reset; a new op a=3, b=5 yields p=15.
- W=8, a=255, b=255 → latency 16, p=65025; step sequences 0..15.
- MULT_SEQ_SKIP_ZERO_EN, W=4: a=4, b=3 → latency 1, p=12. a=0, b=9 → latency 1, p=0. a=15, b=15 → latency 4, p=225.

Source files
------------

// File: rtl/mult_seq_scheduler_pkg.sv
// mult_seq_pkg: shared state encoding, slice geometry and width checks for the sequential multiplier
package mult_seq_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  localparam int SLICE_W = 2;
  function automatic int n_slices(input int w);
    return w / SLICE_W;
  endfunction
  function automatic int n_steps(input int w);
    return n_slices(w) * n_slices(w);
  endfunction
  function automatic bit w_ok(input int w);
    return (w % 2 == 0) && (w >= 4) && (w <= 8);
  endfunction
endpackage

// File: rtl/mult_seq_scheduler_if.sv
// mult_seq_scheduler_if: operand/product valid-ready bundle plus debug status
interface mult_seq_scheduler_if #(parameter int W = 4);
  import mult_seq_pkg::*;
  localparam int SW = $clog2(n_steps(W));
  logic in_valid;
  logic in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic out_valid;
  logic out_ready;
  logic [2*W-1:0] p;
  logic busy;
  logic [SW-1:0] step;
  modport master (output in_valid, a, b, out_ready, input in_ready, out_valid, p, busy, step);
  modport slave (input in_valid, a, b, out_ready, output in_ready, out_valid, p, busy, step);
endinterface

// File: rtl/mult_seq_scheduler_core.sv
// mult2_core: combinational 2x2 unsigned multiply, drop-in slot for alternative 2x2 cores
module mult2_core (
  input  logic [1:0] a,
  input  logic [1:0] b,
  output logic [3:0] p
);
  assign p = {2'b00, a} * {2'b00, b};
endmodule

// File: rtl/mult_seq_scheduler.sv
// mult_seq_scheduler: WxW multiply by stepping one 2x2 core over all slice pairs (MULT_SEQ_SKIP_ZERO_EN skips zero-slice pairs)
module mult_seq_scheduler
  import mult_seq_pkg::*;
#(
  parameter int W = 4
) (
  input logic clk,
  input logic rst_n,
  mult_seq_scheduler_if.slave bus
);
  localparam int N = n_slices(W);
  localparam int S = n_steps(W);
  localparam int IW = $clog2(S);
  localparam bit W_OK = w_ok(W);
  if (!W_OK) begin : g_bad_w
    $error("mult_seq_scheduler: W must be even and in 4..8");
  end
  state_t state, state_nx;
  logic [W-1:0] a_q, b_q, a_sh, b_sh;
  logic [2*W-1:0] acc, pp_sh;
  logic [IW-1:0] idx, idx_nx, first, i, j;
  logic [1:0] a_sl, b_sl;
  logic [3:0] pp;
  logic hit, last;
  wire accept = (state == IDLE) && bus.in_valid;
  mult2_core u_core (.a(a_sl), .b(b_sl), .p(pp));
  // select the slice pair for idx and align its partial product
  always_comb begin
    i = idx / IW'(N);
    j = idx % IW'(N);
    a_sh = a_q >> (SLICE_W * i);
    b_sh = b_q >> (SLICE_W * j);
    a_sl = a_sh[1:0];
    b_sl = b_sh[1:0];
    pp_sh = {{(2*W-4){1'b0}}, pp} << (SLICE_W * (i + j));
  end
`ifdef MULT_SEQ_SKIP_ZERO_EN
  logic [S-1:0] mask_in, mask_q, rem;
  logic [IW-1:0] nxt;
  // nonzero-pair mask of the offered operands and the next pair still to visit
  always_comb begin
    mask_in = '0;
    for (int k = 0; k < S; k++)
      mask_in[k] = (|bus.a[SLICE_W*(k/N) +: SLICE_W]) && (|bus.b[SLICE_W*(k%N) +: SLICE_W]);
    rem = mask_q & ~(S'(1) << idx);
    first = '0;
    nxt = '0;
    for (int k = S - 1; k >= 0; k--) begin
      if (mask_in[k]) first = IW'(k);
      if (rem[k]) nxt = IW'(k);
    end
    hit = mask_q[idx];
    last = rem == '0;
    idx_nx = nxt;
  end
  // pairs still owed a visit; an empty mask leaves one idle RUN cycle
  always_ff @(posedge clk)
    if (!rst_n) mask_q <= '0;
    else if (accept) mask_q <= mask_in;
    else if (state == RUN) mask_q <= rem;
`else
  // visit every pair in row-major order
  always_comb begin
    first = '0;
    hit = 1'b1;
    last = idx == IW'(S - 1);
    idx_nx = last ? '0 : idx + 1'b1;
  end
`endif
  // next state and Moore outputs
  always_comb begin
    state_nx = accept ? RUN :
               (state == RUN && last) ? DONE :
               (state == DONE && bus.out_ready) ? IDLE : state;
    bus.in_ready = state == IDLE;
    bus.out_valid = state == DONE;
    bus.busy = state == RUN;
    bus.step = (state == RUN) ? idx : '0;
    bus.p = acc;
  end
  // state, operand latch, index counter and accumulator
  always_ff @(posedge clk)
    if (!rst_n) begin
      state <= IDLE;
      acc <= '0;
      idx <= '0;
      a_q <= '0;
      b_q <= '0;
    end else begin
      state <= state_nx;
      if (accept) begin
        a_q <= bus.a;
        b_q <= bus.b;
        acc <= '0;
        idx <= first;
      end else if (state == RUN) begin
        acc <= acc + (hit ? pp_sh : '0);
        idx <= idx_nx;
      end
    end
endmodule

// File: tb/tb_mult_seq_scheduler.sv
// tb_mult_seq_scheduler: randomized and directed checks of the sequential multiplier against an arithmetic model
module tb_mult_seq_scheduler;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int total = 0;
  int bad = 0;
  always #5 clk = ~clk;
  mult_seq_scheduler_if #(.W(4)) b4 ();
  mult_seq_scheduler_if #(.W(8)) b8 ();
  mult_seq_scheduler #(.W(4)) dut4 (.clk(clk), .rst_n(rst_n), .bus(b4.slave));
  mult_seq_scheduler #(.W(8)) dut8 (.clk(clk), .rst_n(rst_n), .bus(b8.slave));

  function automatic int exp_lat(input int a, input int b, input int w);
    int n = w / 2;
    int c = 0;
`ifdef MULT_SEQ_SKIP_ZERO_EN
    for (int x = 0; x < n; x++)
      for (int y = 0; y < n; y++)
        if (((a >> (2 * x)) & 3) != 0 && ((b >> (2 * y)) & 3) != 0) c++;
    return (c == 0) ? 1 : c;
`else
    c = n * n;
    return c;
`endif
  endfunction

  task automatic op4(input int a, input int b, output int lat, output int pv);
    b4.a = 4'(a);
    b4.b = 4'(b);
    b4.in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    b4.in_valid = 1'b0;
    b4.a = 4'($urandom);
    b4.b = 4'($urandom);
    lat = 0;
    while (!b4.out_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    pv = int'(b4.p);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    total += 6;
    if (b4.in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b want=1", b4.in_ready); end
    if (b4.out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b want=0", b4.out_valid); end
    if (b4.p !== 8'd0) begin bad++; $display("FAIL reset_p got=%0d want=0", b4.p); end
    if (b4.busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", b4.busy); end
    if (b4.step !== 2'd0) begin bad++; $display("FAIL reset_step got=%0d want=0", b4.step); end
    if (b8.in_ready !== 1'b1) begin bad++; $display("FAIL reset_w8_in_ready got=%b want=1", b8.in_ready); end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_max();
    int lat, pv;
    b4.out_ready = 1'b1;
    op4(15, 15, lat, pv);
    total += 4;
    if (lat != exp_lat(15, 15, 4)) begin bad++; $display("FAIL max_latency got=%0d want=%0d", lat, exp_lat(15, 15, 4)); end
    if (pv != 225) begin bad++; $display("FAIL max_p got=%0d want=225", pv); end
    @(negedge clk);
    if (b4.in_ready !== 1'b1) begin bad++; $display("FAIL max_in_ready_after got=%b want=1", b4.in_ready); end
    if (b4.out_valid !== 1'b0) begin bad++; $display("FAIL max_out_valid_after got=%b want=0", b4.out_valid); end
  endtask

  task automatic test_stall();
    int lat, pv, extra;
    b4.out_ready = 1'b0;
    op4(9, 6, lat, pv);
    total += 2;
    if (lat != exp_lat(9, 6, 4)) begin bad++; $display("FAIL stall_latency got=%0d want=%0d", lat, exp_lat(9, 6, 4)); end
    if (pv != 54) begin bad++; $display("FAIL stall_p got=%0d want=54", pv); end
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      total++;
      if (b4.out_valid !== 1'b1 || b4.p !== 8'd54) begin
        bad++;
        $display("FAIL stall_hold cyc=%0d got_valid=%b got_p=%0d want_valid=1 want_p=54", c, b4.out_valid, b4.p);
      end
    end
    b4.out_ready = 1'b1;
    @(negedge clk);
    total += 2;
    if (b4.out_valid !== 1'b0) begin bad++; $display("FAIL stall_release got=%b want=0", b4.out_valid); end
    if (b4.in_ready !== 1'b1) begin bad++; $display("FAIL stall_in_ready got=%b want=1", b4.in_ready); end
    extra = 0;
    repeat (6) begin
      @(negedge clk);
      if (b4.out_valid) extra++;
    end
    total++;
    if (extra != 0) begin bad++; $display("FAIL stall_second_valid got=%0d want=0", extra); end
  endtask

  task automatic test_back_to_back();
    int q[$];
    int sent = 0;
    int got = 0;
    int cyc = 0;
    int e;
    while (got < 256 && cyc < 20000) begin
      b4.in_valid = sent < 256;
      b4.a = 4'((sent >> 4) & 15);
      b4.b = 4'(sent & 15);
      b4.out_ready = 1'($urandom_range(0, 1));
      if (b4.in_valid && b4.in_ready) begin
        q.push_back(((sent >> 4) & 15) * (sent & 15));
        sent++;
      end
      if (b4.out_valid && b4.out_ready) begin
        total++;
        e = (q.size() > 0) ? q.pop_front() : -1;
        if (int'(b4.p) != e) begin bad++; $display("FAIL b2b_p idx=%0d got=%0d want=%0d", got, b4.p, e); end
        got++;
      end
      @(negedge clk);
      cyc++;
    end
    b4.in_valid = 1'b0;
    b4.out_ready = 1'b1;
    total += 2;
    if (got != 256) begin bad++; $display("FAIL b2b_count got=%0d want=256", got); end
    if (q.size() != 0) begin bad++; $display("FAIL b2b_leftover got=%0d want=0", q.size()); end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_mid_reset();
    int lat, pv, seen;
    b4.out_ready = 1'b1;
    b4.a = 4'd7;
    b4.b = 4'd13;
    b4.in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    b4.in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    total += 2;
    if (b4.in_ready !== 1'b1) begin bad++; $display("FAIL mrst_in_ready got=%b want=1", b4.in_ready); end
    if (b4.busy !== 1'b0) begin bad++; $display("FAIL mrst_busy got=%b want=0", b4.busy); end
    seen = 0;
    repeat (8) begin
      if (b4.out_valid) seen++;
      @(negedge clk);
    end
    total++;
    if (seen != 0) begin bad++; $display("FAIL mrst_ghost_valid got=%0d want=0", seen); end
    op4(3, 5, lat, pv);
    total += 2;
    if (pv != 15) begin bad++; $display("FAIL mrst_new_p got=%0d want=15", pv); end
    if (lat != exp_lat(3, 5, 4)) begin bad++; $display("FAIL mrst_new_latency got=%0d want=%0d", lat, exp_lat(3, 5, 4)); end
    @(negedge clk);
  endtask

  task automatic test_corners();
    int pa[4] = '{4, 0, 0, 15};
    int pb[4] = '{3, 9, 0, 1};
    int lat, pv;
    b4.out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      op4(pa[k], pb[k], lat, pv);
      total += 2;
      if (pv != pa[k] * pb[k]) begin bad++; $display("FAIL corner_p a=%0d b=%0d got=%0d want=%0d", pa[k], pb[k], pv, pa[k] * pb[k]); end
      if (lat != exp_lat(pa[k], pb[k], 4)) begin bad++; $display("FAIL corner_latency a=%0d b=%0d got=%0d want=%0d", pa[k], pb[k], lat, exp_lat(pa[k], pb[k], 4)); end
      @(negedge clk);
    end
  endtask

  task automatic test_random();
    int a, b, lat, pv;
    b4.out_ready = 1'b1;
    repeat (30) begin
      a = int'($urandom_range(0, 15));
      b = int'($urandom_range(0, 15));
      op4(a, b, lat, pv);
      total += 2;
      if (pv != a * b) begin bad++; $display("FAIL rand_p a=%0d b=%0d got=%0d want=%0d", a, b, pv, a * b); end
      if (lat != exp_lat(a, b, 4)) begin bad++; $display("FAIL rand_latency a=%0d b=%0d got=%0d want=%0d", a, b, lat, exp_lat(a, b, 4)); end
      @(negedge clk);
    end
  endtask

  task automatic test_w8(input int a, input int b, input bit chk_steps);
    int lat = 0;
    b8.out_ready = 1'b1;
    b8.a = 8'(a);
    b8.b = 8'(b);
    b8.in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    b8.in_valid = 1'b0;
    while (!b8.out_valid && lat < 40) begin
      if (chk_steps) begin
        total++;
        if (b8.busy !== 1'b1 || int'(b8.step) != lat) begin
          bad++;
          $display("FAIL w8_step cyc=%0d got_busy=%b got_step=%0d want_busy=1 want_step=%0d", lat, b8.busy, b8.step, lat);
        end
      end
      @(negedge clk);
      lat++;
    end
    total += 3;
    if (lat != exp_lat(a, b, 8)) begin bad++; $display("FAIL w8_latency a=%0d b=%0d got=%0d want=%0d", a, b, lat, exp_lat(a, b, 8)); end
    if (int'(b8.p) != a * b) begin bad++; $display("FAIL w8_p a=%0d b=%0d got=%0d want=%0d", a, b, b8.p, a * b); end
    if (b8.step !== 4'd0) begin bad++; $display("FAIL w8_step_done got=%0d want=0", b8.step); end
    @(negedge clk);
  endtask

  initial begin
    b4.in_valid = 1'b0;
    b4.a = '0;
    b4.b = '0;
    b4.out_ready = 1'b0;
    b8.in_valid = 1'b0;
    b8.a = '0;
    b8.b = '0;
    b8.out_ready = 1'b0;
    @(negedge clk);
    test_reset();
    test_max();
    test_stall();
    test_back_to_back();
    test_mid_reset();
    test_corners();
    test_random();
    test_w8(255, 255, 1'b1);
    repeat (10) test_w8(int'($urandom_range(0, 255)), int'($urandom_range(0, 255)), 1'b0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
